ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs,
//   0xFF reset) to the keyboard over the shared PS2_CLK/PS2_DATA open-drain pair.
//   Sits beside the keyboard receive decoder in the top level and drives the pins
//   through tri-state buffers: pin = oe ? 1'b0 : 1'bz.
// PARAMETERS
//   INHIBIT_CYC  12000   clk cycles PS2_CLK is held low before request-to-send (120 us @100 MHz)
//   TIMEOUT_CYC  200000  max clk cycles between device clock falling edges (2 ms)
// PORTS
//   clk         in   1  system clock, 100 MHz
//   rst         in   1  reset; asynchronous, active-high
//   tx_data     in   8  byte to send; sampled on accept
//   tx_valid    in   1  request; accepted when tx_valid & tx_ready
//   tx_ready    out  1  high only in IDLE
//   busy        out  1  ~tx_ready; top level ignores receiver output while high
//   ps2_clk_i   in   1  PS2_CLK pin level (asynchronous)
//   ps2_data_i  in   1  PS2_DATA pin level (asynchronous)
//   ps2_clk_oe  out  1  1 = pull PS2_CLK low
//   ps2_data_oe out  1  1 = pull PS2_DATA low
//   tx_done     out  1  1-cycle pulse: byte acknowledged and bus idle
//   tx_err      out  1  1-cycle pulse: NACK or timeout
// BEHAVIOUR
//   - Reset: state IDLE; tx_ready=1, busy=0, both oe=0, tx_done=tx_err=0. Async reset
//     mid-transfer releases both lines immediately; no done/err pulse is issued.
//   - ps2_clk_i/ps2_data_i pass through 2-FF synchronizers. fall = prev_sync & ~cur_sync.
//   - Frame: shift = {stop=1, parity=~^tx_data, tx_data[7:0]}, LSB first, 10 bits.
//     Parity is odd. ps2_data_oe = ~current_bit.
//   - IDLE: on accept, latch frame, load counter, go to INHIBIT.
//   - INHIBIT: clk_oe=1 for exactly INHIBIT_CYC cycles. ps2_data_oe=1 (start bit)
//     from the last INHIBIT cycle onward. Then go to SEND with clk_oe=0.
//   - SEND: bit counter 0..9. On each fall, drive shift[cnt] and increment cnt.
//     The 10th fall drives stop (data_oe=0). Then go to ACK.
//   - ACK: on the next (11th) fall, sample synced data. 0 -> WAIT_IDLE; 1 -> NACK.
//   - WAIT_IDLE: wait for synced clk=1 and data=1, then pulse tx_done and go to IDLE.
//   - Timeout: a timer resets on every fall in SEND/ACK/WAIT_IDLE. When it reaches
//     TIMEOUT_CYC: both oe=0, pulse tx_err, go to IDLE.
//   - NACK: both oe=0, pulse tx_err, go to IDLE (see CONFIGURATION).
//   - tx_valid while busy: not accepted, no effect. tx_done and tx_err are never
//     high in the same cycle. tx_ready rises the cycle after the done/err pulse.
//   - ps2_clk_oe and ps2_data_oe are registered outputs (glitch-free).
// CONFIGURATION
//   PS2_TX_RESEND_EN defined:
//     - On the first NACK or timeout, automatically restart from INHIBIT with the
//       same latched byte. No tx_err on that attempt.
//     - tx_err pulses only if the retry also fails. Max 2 attempts per accept.
//   PS2_TX_RESEND_EN undefined:
//     - The first NACK or timeout pulses tx_err. No retry logic is synthesized.
// TESTING  (INHIBIT_CYC=100, TIMEOUT_CYC=2000; device model: 40-cycle clock period,
//           samples data on rising edges)
//   1. Send 0xED, device ACKs -> model reads start 0, bits 1,0,1,1,0,1,1,1, parity 1,
//      stop 1; one tx_done pulse; tx_err=0; tx_ready=1 afterwards.
//   2. Accept 0x00 -> clk_oe high exactly 100 cycles; data_oe rises in cycle 100;
//      parity bit 1; tx_done.
//   3. Device holds data high at the 11th fall -> without macro: tx_err pulse, no second
//      INHIBIT. With macro: second INHIBIT occurs; second NACK -> one tx_err total.
//   4. Device never clocks after request-to-send -> tx_err 2000 cycles into SEND;
//      both oe=0; tx_ready=1.
//   5. Assert rst during SEND at bit 4 -> both oe=0 in the same cycle, no pulses.
//      Next send of 0xFF succeeds: parity 1, tx_done.
//   6. Hold tx_valid high with 0x55 then 0xAA across a transfer -> 0x55 sent;
//      0xAA accepted only after tx_ready returns; exactly two frames on the bus.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
// Sends one command byte to the device over the open-drain PS2_CLK/PS2_DATA pair.
// The top level drives each pin as: pin = oe ? 1'b0 : 1'bz.
//
// Parameters:
//   INHIBIT_CYC  cycles PS2_CLK is held low before request-to-send
//   TIMEOUT_CYC  max cycles between device clock falling edges
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   tx_data, tx_valid        byte to send and its request (accepted when tx_ready)
//   tx_ready, busy           ready only in IDLE; busy = ~tx_ready
//   ps2_clk_i, ps2_data_i    raw pin levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe  1 = pull the pin low (registered)
//   tx_done, tx_err          1-cycle completion / failure pulses
// Build option:
//   PS2_TX_RESEND_EN  when defined, the first NACK or timeout restarts the frame
//                     once with the same byte; tx_err only if the retry fails too.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int MAXC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;  // pulse cycle, so tx_ready rises one cycle later

  logic [2:0]    state_q, state_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;     // inhibit down-counter, then inter-edge timer
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          done_q, done_d, err_q, err_d;
`ifdef PS2_TX_RESEND_EN
  logic          retry_q, retry_d;
`endif

  // Pin synchronizers; idle bus level is high.
  logic clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
  logic fall, fail, timeout;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retry_d   = retry_q;
`endif
    fail      = 1'b0;
    timeout   = 1'b0;

    if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT) begin
      cnt_d   = fall ? '0 : cnt_q + 1'b1;
      timeout = !fall && (cnt_q == CW'(TIMEOUT_CYC - 1));
    end

    case (state_q)
      S_IDLE: if (tx_valid) begin
        frame_d   = {1'b1, ~^tx_data, tx_data};
        bit_d     = '0;
        cnt_d     = CW'(INHIBIT_CYC - 1);
        clk_oe_d  = 1'b1;
        data_oe_d = (INHIBIT_CYC == 1);
`ifdef PS2_TX_RESEND_EN
        retry_d   = 1'b0;
`endif
        state_d   = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (cnt_q == '0) begin
          clk_oe_d = 1'b0;
          state_d  = S_SEND;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Start bit goes out in the last inhibit cycle.
          if (cnt_q == CW'(1)) data_oe_d = 1'b1;
        end
      end
      S_SEND: if (fall) begin
        data_oe_d = ~frame_q[bit_q];
        bit_d     = bit_q + 4'd1;
        if (bit_q == 4'd9) state_d = S_ACK;
      end
      S_ACK: if (fall) begin
        if (dat_sync_q) fail = 1'b1;
        else            state_d = S_WAIT;
      end
      S_WAIT: if (clk_sync_q && dat_sync_q) begin
        done_d  = 1'b1;
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail || timeout) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
`ifdef PS2_TX_RESEND_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        bit_d     = '0;
        cnt_d     = CW'(INHIBIT_CYC - 1);
        clk_oe_d  = 1'b1;
        data_oe_d = (INHIBIT_CYC == 1);
        state_d   = S_INHIBIT;
      end else
`endif
      begin
        err_d   = 1'b1;
        state_d = S_FIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= 1'b0;
`endif
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_RESEND_EN
      retry_q    <= retry_d;
`endif
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model (40-cycle clock, samples on rising
// edges) on a wired-AND bus; expected bytes are queued on request and checked
// against every frame the device model captures.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TMO = 2000;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  logic       ps2_clk, ps2_data;

  assign ps2_clk  = ~(ps2_clk_oe  | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, acc_cnt = 0;
  int t_rts = 0, t_err = 0;
  logic prev_clk_oe = 1'b0, rdy_pulse = 1'b0;
  logic [1:0] oe_err = 2'b00;
  logic [7:0] q_exp[$];

  // Event monitor (values visible to the test one negedge later).
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) begin err_cnt <= err_cnt + 1; t_err <= cyc; oe_err <= {ps2_clk_oe, ps2_data_oe}; end
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (tx_done || tx_err) rdy_pulse <= tx_ready;
    if (ps2_clk_oe && !prev_clk_oe) inh_cnt <= inh_cnt + 1;
    if (!ps2_clk_oe && prev_clk_oe) t_rts <= cyc;
    if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    prev_clk_oe <= ps2_clk_oe;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  // Device: wait for request-to-send, read start bit, clock 11 falls, read bits
  // on rising edges, ack (or not) at the 11th fall. abort_at>0 stops after that fall.
  task automatic dev_frame(input bit ack, input int abort_at);
    logic [10:0] b, e11;
    logic [7:0]  e;
    int t = 0;
    b = '0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 6000) begin @(negedge clk); t++; end
    if (t >= 6000) begin
      n_chk++; $display("FAIL rts_wait: no request-to-send within 6000 cycles");
      return;
    end
    repeat (10) @(negedge clk);
    b[0] = ps2_data;
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      if (abort_at == k) return;
      if (k <= 10) b[k] = ps2_data;
      if (k == 10) dev_dat_low = ack;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    n_chk++;
    if (q_exp.size() == 0) begin
      $display("FAIL frame: got %b with no expected byte queued", b);
    end else begin
      e   = q_exp.pop_front();
      e11 = {1'b1, ~^e, e, 1'b0};
      if (b !== e11) $display("FAIL frame: got %b expected %b", b, e11);
      else n_pass++;
    end
  endtask

  task automatic send(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    tx_data = d; tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 6000) begin @(negedge clk); t++; end
    n_chk++;
    if (t >= 6000) $display("FAIL accept: tx_ready stayed %b for 6000 cycles", tx_ready);
    else n_pass++;
    q_exp.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_end(input int base, input int lim, output bit ok);
    int t = 0;
    while (done_cnt + err_cnt == base && t < lim) begin @(negedge clk); t++; end
    ok = (done_cnt + err_cnt != base);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (tx_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", tx_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (ps2_clk_oe !== 1'b0) $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
    n_chk++; if (ps2_data_oe !== 1'b0) $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); else n_pass++;
    n_chk++; if (tx_done !== 1'b0) $display("FAIL rst_done: got %b want 0", tx_done); else n_pass++;
    n_chk++; if (tx_err !== 1'b0) $display("FAIL rst_err: got %b want 0", tx_err); else n_pass++;
  endtask

  task automatic test_ack_ed();
    int bd = done_cnt, be = err_cnt;
    bit ok;
    fork
      dev_frame(1'b1, 0);
      send(8'hED);
    join
    wait_end(bd + be, 500, ok);
    n_chk++; if (!ok) $display("FAIL ed_end: no done/err pulse within 500 cycles"); else n_pass++;
    n_chk++; if (done_cnt - bd !== 1) $display("FAIL ed_done: got %0d pulses want 1", done_cnt - bd); else n_pass++;
    n_chk++; if (err_cnt - be !== 0) $display("FAIL ed_err: got %0d pulses want 0", err_cnt - be); else n_pass++;
    n_chk++; if (rdy_pulse !== 1'b0) $display("FAIL ed_ready_in_pulse: got %b want 0", rdy_pulse); else n_pass++;
    n_chk++; if (tx_ready !== 1'b1) $display("FAIL ed_ready_after: got %b want 1", tx_ready); else n_pass++;
  endtask

  task automatic test_inhibit_timing();
    int bd = done_cnt, n = 0, first = 0;
    bit ok;
    fork
      dev_frame(1'b1, 0);
      begin
        send(8'h00);
        while (ps2_clk_oe === 1'b1 && n < 1000) begin
          n++;
          if (ps2_data_oe === 1'b1 && first == 0) first = n;
          @(negedge clk);
        end
      end
    join
    n_chk++; if (n !== INH) $display("FAIL inh_len: clk_oe high %0d cycles want %0d", n, INH); else n_pass++;
    n_chk++; if (first !== INH) $display("FAIL inh_start: data_oe rose in cycle %0d want %0d", first, INH); else n_pass++;
    wait_end(bd + err_cnt, 500, ok);
    n_chk++; if (done_cnt - bd !== 1) $display("FAIL zero_done: got %0d pulses want 1", done_cnt - bd); else n_pass++;
  endtask

  task automatic test_nack();
    int bd = done_cnt, be = err_cnt, bi = inh_cnt;
    bit ok;
`ifdef PS2_TX_RESEND_EN
    fork
      begin dev_frame(1'b0, 0); dev_frame(1'b0, 0); end
      begin send(8'hA5); q_exp.push_back(8'hA5); end
    join
    wait_end(bd + be, 500, ok);
    repeat (300) @(negedge clk);
    n_chk++; if (inh_cnt - bi !== 2) $display("FAIL nack_inhibits: got %0d want 2", inh_cnt - bi); else n_pass++;
`else
    fork
      dev_frame(1'b0, 0);
      send(8'hA5);
    join
    wait_end(bd + be, 500, ok);
    repeat (300) @(negedge clk);
    n_chk++; if (inh_cnt - bi !== 1) $display("FAIL nack_inhibits: got %0d want 1", inh_cnt - bi); else n_pass++;
`endif
    n_chk++; if (err_cnt - be !== 1) $display("FAIL nack_err: got %0d pulses want 1", err_cnt - be); else n_pass++;
    n_chk++; if (done_cnt - bd !== 0) $display("FAIL nack_done: got %0d pulses want 0", done_cnt - bd); else n_pass++;
    n_chk++; if (oe_err !== 2'b00) $display("FAIL nack_oe: got %b want 00", oe_err); else n_pass++;
  endtask

  task automatic test_timeout();
    int be = err_cnt, bi = inh_cnt;
    bit ok;
    send(8'h81);
    wait_end(done_cnt + be, 6000, ok);
    n_chk++; if (!ok) $display("FAIL tmo_end: no pulse within 6000 cycles"); else n_pass++;
    n_chk++; if (err_cnt - be !== 1) $display("FAIL tmo_err: got %0d pulses want 1", err_cnt - be); else n_pass++;
    n_chk++;
    if (t_err - t_rts < TMO - 2 || t_err - t_rts > TMO + 2)
      $display("FAIL tmo_time: err %0d cycles into SEND want %0d", t_err - t_rts, TMO);
    else n_pass++;
    n_chk++; if (oe_err !== 2'b00) $display("FAIL tmo_oe: got %b want 00", oe_err); else n_pass++;
    n_chk++; if (tx_ready !== 1'b1) $display("FAIL tmo_ready: got %b want 1", tx_ready); else n_pass++;
`ifdef PS2_TX_RESEND_EN
    n_chk++; if (inh_cnt - bi !== 2) $display("FAIL tmo_inhibits: got %0d want 2", inh_cnt - bi); else n_pass++;
`else
    n_chk++; if (inh_cnt - bi !== 1) $display("FAIL tmo_inhibits: got %0d want 1", inh_cnt - bi); else n_pass++;
`endif
    if (q_exp.size() != 0) void'(q_exp.pop_front());
  endtask

  task automatic test_reset_mid();
    int bd, be;
    bit ok;
    fork
      dev_frame(1'b1, 5);
      send(8'h00);
    join
    repeat (3) @(negedge clk);
    bd = done_cnt; be = err_cnt;
    n_chk++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_data_oe: got %b want 1 before reset", ps2_data_oe); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL mid_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); else n_pass++;
    n_chk++; if (tx_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", tx_ready); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (done_cnt + err_cnt !== bd + be) $display("FAIL mid_pulses: got %0d want 0", done_cnt + err_cnt - bd - be); else n_pass++;
    if (q_exp.size() != 0) void'(q_exp.pop_front());
    bd = done_cnt;
    fork
      dev_frame(1'b1, 0);
      send(8'hFF);
    join
    wait_end(bd + err_cnt, 500, ok);
    n_chk++; if (done_cnt - bd !== 1) $display("FAIL ff_done: got %0d pulses want 1", done_cnt - bd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bd = done_cnt, ba = acc_cnt, bi = inh_cnt, t;
    bit ok;
    q_exp.push_back(8'h55);
    q_exp.push_back(8'hAA);
    fork
      begin dev_frame(1'b1, 0); dev_frame(1'b1, 0); end
      begin
        @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1;
        t = 0; while (acc_cnt < ba + 1 && t < 3000) begin @(negedge clk); t++; end
        @(negedge clk);
        tx_data = 8'hAA;
        t = 0; while (acc_cnt < ba + 2 && t < 6000) begin @(negedge clk); t++; end
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    t = 0; while (done_cnt < bd + 2 && t < 500) begin @(negedge clk); t++; end
    repeat (300) @(negedge clk);
    n_chk++; if (acc_cnt - ba !== 2) $display("FAIL b2b_accepts: got %0d want 2", acc_cnt - ba); else n_pass++;
    n_chk++; if (inh_cnt - bi !== 2) $display("FAIL b2b_frames: got %0d want 2", inh_cnt - bi); else n_pass++;
    n_chk++; if (done_cnt - bd !== 2) $display("FAIL b2b_done: got %0d want 2", done_cnt - bd); else n_pass++;
    n_chk++; if (q_exp.size() !== 0) $display("FAIL b2b_queue: %0d bytes never framed", q_exp.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_inhibit_timing();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_chk++; if (both_cnt !== 0) $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
